focus_sweep_ctrl: RTL and testbench
===================================

FOCUS_SWEEP_CTRL -- requirements
Module: focus_sweep_ctrl

Interface
REQ-001 SHALL have parameter POS_MAX, default 1023, meaning the highest VCM position code.
REQ-002 SHALL have parameter COARSE_STEP, default 32, meaning the coarse-sweep position increment.
REQ-003 SHALL have parameter FINE_STEP, default 4, meaning the fine-sweep position increment.
REQ-004 SHALL have parameter SETTLE_FRAMES, default 2, meaning the number of frames discarded after each move.
REQ-005 SHALL have parameter SHARP_W, default 32, meaning the sharpness metric width.
REQ-006 SHALL have port VIDEO_CLK, input, 1 bit: the single clock.
REQ-007 SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port START, input, 1 bit: one-cycle autofocus request.
REQ-009 SHALL have port FRAME_END, input, 1 bit: one-cycle pulse at end of each frame.
REQ-010 SHALL have port SHARP, input, SHARP_W bits: frame sharpness, valid in the FRAME_END cycle.
REQ-011 SHALL have port I2C_BUSY, input, 1 bit: the VCM I2C writer is busy.
REQ-012 SHALL have port VCM_POS, output, 10 bits: the commanded VCM position.
REQ-013 SHALL have port VCM_WR, output, 1 bit: one-cycle write request for VCM_POS.
REQ-014 SHALL have port BUSY, output, 1 bit: a sweep is in progress.
REQ-015 SHALL have port VCM_END, output, 1 bit: level, high after a completed sweep.
REQ-016 SHALL have port PEAK_POS, output, 10 bits: the best position found.

Function
REQ-017 SHALL implement states IDLE, MOVE, SETTLE, MEASURE, EVAL, PARK.
REQ-018 IDLE: START SHALL load pos=0, best_sharp=0, best_pos=0, phase=COARSE, lo=0, hi=POS_MAX, clear VCM_END, and go to MOVE.
REQ-019 MOVE: when I2C_BUSY is low, VCM_WR SHALL pulse exactly one cycle with VCM_POS=pos, then the FSM SHALL enter SETTLE; while I2C_BUSY is high it SHALL wait.
REQ-020 SETTLE: SHALL count SETTLE_FRAMES FRAME_END pulses and then enter MEASURE; a FRAME_END in the MOVE cycle SHALL NOT be counted.
REQ-021 MEASURE: the next FRAME_END SHALL capture SHARP, then the FSM SHALL enter EVAL.
REQ-022 EVAL: if captured > best_sharp (strict), best_sharp and best_pos SHALL update; on a tie the earlier position SHALL be kept.
REQ-023 EVAL next position: next = pos + step, computed 11 bits wide; if next <= hi, pos=next and the FSM SHALL go to MOVE.
REQ-024 At the COARSE end, SHALL set phase=FINE, lo=max(0, best_pos-COARSE_STEP), hi=min(POS_MAX, best_pos+COARSE_STEP), pos=lo, keep best_sharp, and go to MOVE.
REQ-025 At the FINE end, SHALL set pos=best_pos, PEAK_POS=best_pos, and go to PARK.
REQ-026 PARK: SHALL issue one VCM_WR (same I2C_BUSY rule), then set VCM_END=1 and return to IDLE.
REQ-027 BUSY SHALL be high in every state except IDLE.
REQ-028 START while BUSY SHALL be ignored.
REQ-029 START in IDLE with VCM_END=1 SHALL start a new sweep.
REQ-030 SHARP at all-ones SHALL be handled without overflow; the comparison is unsigned.
REQ-031 VCM_POS SHALL hold its last value between writes.

Reset
REQ-032 On RESET_N low, outputs SHALL be set asynchronously: VCM_POS=0, VCM_WR=0, BUSY=0, VCM_END=0, PEAK_POS=0.
REQ-033 On RESET_N low, state SHALL be IDLE and all counters and best registers SHALL be 0.
REQ-034 Reset mid-sweep SHALL abandon the sweep with no further VCM_WR.

Structure
REQ-035 The state encoding, the phase enum, and default constants SHALL reside in the shared package focus_pkg.
REQ-036 The frame settle/measure counter SHALL be the sub-module frame_wait_cnt (start, FRAME_END, count target, done pulse).

Verification
REQ-037 Coarse peak: sharpness peaks at position 320 (parabolic model) -> coarse best=320, fine range 288..352, PEAK_POS=320, final VCM_WR with VCM_POS=320, VCM_END=1.
REQ-038 Edge clamp: peak at 0 -> fine lo=0, hi=32, no negative wrap, PEAK_POS=0; peak at 1023 -> hi=1023, last coarse position 992 handled.
REQ-039 Tie: equal SHARP=1000 at 96 and 128 -> PEAK_POS=96.
REQ-040 Handshake: I2C_BUSY held high for 50 cycles in MOVE -> VCM_WR issued only after it drops, exactly once.
REQ-041 Settle: SETTLE_FRAMES=2 -> capture occurs on the third FRAME_END after each VCM_WR; START pulsed mid-sweep -> ignored.
REQ-042 Reset during FINE phase -> all outputs 0 immediately; a new START restarts from position 0.

Source files
------------

// File: rtl/focus_pkg.sv
// Shared types and default constants for the autofocus sweep controller.
package focus_pkg;

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 8;

  localparam int unsigned DEF_POS_MAX       = 1023;
  localparam int unsigned DEF_COARSE_STEP   = 32;
  localparam int unsigned DEF_FINE_STEP     = 4;
  localparam int unsigned DEF_SETTLE_FRAMES = 2;
  localparam int unsigned DEF_SHARP_W       = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_PARK
  } state_t;

  typedef enum logic {
    PH_COARSE,
    PH_FINE
  } phase_t;

endpackage

// File: rtl/frame_wait_cnt.sv
// Counts FRAME_END pulses while enabled; pulses o_done on the pulse that reaches i_target.
module frame_wait_cnt
  import focus_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic             i_frame_end,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_cnt_inc;

  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign o_done    = i_en && i_frame_end && (w_cnt_inc >= {1'b0, i_target});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_en && i_frame_end) begin
      r_cnt <= o_done ? '0 : w_cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/focus_sweep_ctrl.sv
// Contrast-detect autofocus: coarse VCM sweep, fine sweep around the best coarse
// position, then park the lens at the sharpest position found.
module focus_sweep_ctrl
  import focus_pkg::*;
#(
  parameter int unsigned POS_MAX       = DEF_POS_MAX,
  parameter int unsigned COARSE_STEP   = DEF_COARSE_STEP,
  parameter int unsigned FINE_STEP     = DEF_FINE_STEP,
  parameter int unsigned SETTLE_FRAMES = DEF_SETTLE_FRAMES,
  parameter int unsigned SHARP_W       = DEF_SHARP_W
)(
  input  logic               VIDEO_CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               FRAME_END,
  input  logic [SHARP_W-1:0] SHARP,
  input  logic               I2C_BUSY,
  output logic [POS_W-1:0]   VCM_POS,
  output logic               VCM_WR,
  output logic               BUSY,
  output logic               VCM_END,
  output logic [POS_W-1:0]   PEAK_POS
);

  localparam logic [POS_W:0]   L_POS_MAX = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]   L_COARSE  = (POS_W+1)'(COARSE_STEP);
  localparam logic [POS_W:0]   L_FINE    = (POS_W+1)'(FINE_STEP);
  localparam logic [CNT_W-1:0] L_SETTLE  = CNT_W'(SETTLE_FRAMES);
  localparam logic [CNT_W-1:0] L_ONE     = CNT_W'(1);

  state_t             r_state, w_state_nxt;
  phase_t             r_phase;
  logic [POS_W-1:0]   r_pos, r_hi, r_best_pos, r_vcm_pos, r_peak_pos;
  logic [SHARP_W-1:0] r_best_sharp, r_cap;
  logic               r_vcm_wr, r_vcm_end;

  logic [POS_W:0]     w_step, w_next, w_hi_sum, w_lo_diff;
  logic [POS_W-1:0]   w_bp, w_lo, w_hi;
  logic               w_next_ok, w_better;
  logic               w_cnt_start, w_cnt_en, w_done;
  logic [CNT_W-1:0]   w_cnt_target;

  frame_wait_cnt u_wait (
    .i_clk       (VIDEO_CLK),
    .i_rst_n     (RESET_N),
    .i_start     (w_cnt_start),
    .i_en        (w_cnt_en),
    .i_frame_end (FRAME_END),
    .i_target    (w_cnt_target),
    .o_done      (w_done)
  );

  // Counter restarts on the write cycle, so a FRAME_END in MOVE is never counted.
  assign w_cnt_en     = (r_state == S_SETTLE) || (r_state == S_MEASURE);
  assign w_cnt_target = (r_state == S_MEASURE) ? L_ONE : L_SETTLE;
  assign w_cnt_start  = ((r_state == S_MOVE) && !I2C_BUSY) ||
                        ((r_state == S_SETTLE) && w_done);

  always_comb begin
    w_step    = (r_phase == PH_FINE) ? L_FINE : L_COARSE;
    w_next    = {1'b0, r_pos} + w_step;
    w_next_ok = (w_next <= {1'b0, r_hi});
    w_better  = (r_cap > r_best_sharp);
    // Fine window is derived from the best position including this cycle's update.
    w_bp      = w_better ? r_pos : r_best_pos;
    w_lo_diff = {1'b0, w_bp} - L_COARSE;
    w_hi_sum  = {1'b0, w_bp} + L_COARSE;
    w_lo      = ({1'b0, w_bp} >= L_COARSE) ? w_lo_diff[POS_W-1:0] : '0;
    w_hi      = (w_hi_sum > L_POS_MAX) ? L_POS_MAX[POS_W-1:0] : w_hi_sum[POS_W-1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (START) w_state_nxt = S_MOVE;
      S_MOVE:    if (!I2C_BUSY) w_state_nxt = (SETTLE_FRAMES == 0) ? S_MEASURE : S_SETTLE;
      S_SETTLE:  if (w_done) w_state_nxt = S_MEASURE;
      S_MEASURE: if (w_done) w_state_nxt = S_EVAL;
      S_EVAL:    w_state_nxt = (w_next_ok || (r_phase == PH_COARSE)) ? S_MOVE : S_PARK;
      S_PARK:    if (!I2C_BUSY) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge VIDEO_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_phase      <= PH_COARSE;
      r_pos        <= '0;
      r_hi         <= '0;
      r_best_pos   <= '0;
      r_best_sharp <= '0;
      r_cap        <= '0;
      r_vcm_pos    <= '0;
      r_vcm_wr     <= 1'b0;
      r_vcm_end    <= 1'b0;
      r_peak_pos   <= '0;
    end else begin
      r_vcm_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_pos        <= '0;
            r_best_sharp <= '0;
            r_best_pos   <= '0;
            r_phase      <= PH_COARSE;
            r_hi         <= L_POS_MAX[POS_W-1:0];
            r_vcm_end    <= 1'b0;
          end
        end
        S_MOVE, S_PARK: begin
          if (!I2C_BUSY) begin
            r_vcm_wr  <= 1'b1;
            r_vcm_pos <= r_pos;
            if (r_state == S_PARK) r_vcm_end <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (w_done) r_cap <= SHARP;
        end
        S_EVAL: begin
          if (w_better) begin
            r_best_sharp <= r_cap;
            r_best_pos   <= r_pos;
          end
          if (w_next_ok) begin
            r_pos <= w_next[POS_W-1:0];
          end else if (r_phase == PH_COARSE) begin
            r_phase <= PH_FINE;
            r_hi    <= w_hi;
            r_pos   <= w_lo;
          end else begin
            r_pos      <= w_bp;
            r_peak_pos <= w_bp;
          end
        end
        default: ;
      endcase
    end
  end

  assign VCM_POS  = r_vcm_pos;
  assign VCM_WR   = r_vcm_wr;
  assign BUSY     = (r_state != S_IDLE);
  assign VCM_END  = r_vcm_end;
  assign PEAK_POS = r_peak_pos;

endmodule

// File: tb/tb_focus_sweep_ctrl.sv
// Bench for focus_sweep_ctrl: sharpness is a function of the commanded position,
// and the expected write sequence is computed up front from the sweep rules.
module tb_focus_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        frame_end = 1'b0;
  logic [31:0] sharp = '0;
  logic        i2c_busy = 1'b0;
  logic [9:0]  vcm_pos;
  logic        vcm_wr;
  logic        busy;
  logic        vcm_end;
  logic [9:0]  peak_pos;

  always #5 clk = ~clk;

  focus_sweep_ctrl #(
    .POS_MAX       (1023),
    .COARSE_STEP   (32),
    .FINE_STEP     (4),
    .SETTLE_FRAMES (2),
    .SHARP_W       (32)
  ) dut (
    .VIDEO_CLK (clk),
    .RESET_N   (rst_n),
    .START     (start),
    .FRAME_END (frame_end),
    .SHARP     (sharp),
    .I2C_BUSY  (i2c_busy),
    .VCM_POS   (vcm_pos),
    .VCM_WR    (vcm_wr),
    .BUSY      (busy),
    .VCM_END   (vcm_end),
    .PEAK_POS  (peak_pos)
  );

  int total = 0;
  int bad = 0;

  int q[$];
  int mode = 0;
  int peak_next = 0, exp_peak = 0, last_pos = 0;
  int first_fine = 0, last_fine = 0, last_coarse = 0;
  bit sweep_on = 0, end_exp = 0;
  int wr_count = 0;
  int frames = 0;
  bit win_valid = 0, busy_seen = 0, prev_busy = 0;
  int fcnt = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sharp_of(input int m, input int p);
    longint d;
    int c;
    case (m)
      0:       c = 320;
      1:       c = 0;
      2:       c = 1023;
      default: return ((p == 96) || (p == 128)) ? 32'd1000 : 32'd10;
    endcase
    d = longint'(p) - longint'(c);
    return 32'(64'hFFFF_FFFF - d * d);
  endfunction

  // Expected VCM write sequence: coarse positions, fine window, then the park write.
  task automatic build_model(input int m);
    logic [31:0] bs, s;
    int bp, lo, hi, n_coarse;
    q.delete();
    bs = '0;
    bp = 0;
    for (int p = 0; p <= 1023; p += 32) begin
      q.push_back(p);
      s = sharp_of(m, p);
      if (s > bs) begin bs = s; bp = p; end
    end
    n_coarse = q.size();
    last_coarse = q[n_coarse-1];
    lo = (bp >= 32) ? bp - 32 : 0;
    hi = (bp + 32 > 1023) ? 1023 : bp + 32;
    for (int p = lo; p <= hi; p += 4) begin
      q.push_back(p);
      s = sharp_of(m, p);
      if (s > bs) begin bs = s; bp = p; end
    end
    first_fine = q[n_coarse];
    last_fine = q[q.size()-1];
    q.push_back(bp);
    peak_next = bp;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      fcnt++;
      frame_end = ((fcnt % 8) == 0);
      sharp = sharp_of(mode, int'(vcm_pos));
    end
  end

  // Per-cycle compare against the model
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 0;
      end else begin
        if (vcm_wr) begin
          check("wr_while_i2c_busy", prev_busy, 0);
          if (win_valid && !busy_seen) check("settle_frames", frames, 3);
          frames = frame_end ? 1 : 0;
          busy_seen = i2c_busy;
          win_valid = 1;
          if (q.size() == 0) begin
            check("unexpected_wr", 1, 0);
          end else begin
            e = q.pop_front();
            check("wr_pos", vcm_pos, e);
            wr_count++;
            last_pos = e;
            if (q.size() == 0) begin
              sweep_on = 0;
              end_exp = 1;
              exp_peak = peak_next;
              win_valid = 0;
              check("park_busy", busy, 0);
              check("park_end", vcm_end, 1);
              check("park_peak", peak_pos, exp_peak);
            end else begin
              check("sweep_busy", busy, 1);
              check("sweep_end", vcm_end, 0);
            end
          end
        end else begin
          frames += frame_end ? 1 : 0;
          busy_seen |= i2c_busy;
          check("pos_hold", vcm_pos, last_pos);
          check("busy", busy, sweep_on);
          check("end_flag", vcm_end, end_exp);
          if (!sweep_on) check("peak_hold", peak_pos, exp_peak);
        end
        prev_busy = i2c_busy;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("rst_vcm_pos", vcm_pos, 0);
    check("rst_vcm_wr", vcm_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_vcm_end", vcm_end, 0);
    check("rst_peak_pos", peak_pos, 0);
    q.delete();
    sweep_on = 0; end_exp = 0; exp_peak = 0; last_pos = 0; win_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
  endtask

  task automatic start_sweep(input int m);
    @(posedge clk);
    #1;
    mode = m;
    build_model(m);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    sweep_on = 1; end_exp = 0; win_valid = 0; wr_count = 0;
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_count < n && k < 5000) begin @(posedge clk); k++; end
    #1;
    check("wr_reached", (wr_count >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (sweep_on && k < 5000) begin @(posedge clk); k++; end
    #1;
    check("sweep_done", sweep_on, 0);
  endtask

  initial begin
    int c0, k;
    do_reset();

    // Peak at 320, with an ignored START and a long I2C busy stall mid-sweep
    start_sweep(0);
    check("model_fine_lo_320", first_fine, 288);
    check("model_fine_hi_320", last_fine, 352);
    check("model_peak_320", peak_next, 320);
    wait_wr(5);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_wr(8);
    c0 = wr_count;
    i2c_busy = 1;
    repeat (50) @(posedge clk);
    #1;
    check("no_wr_while_busy", wr_count, c0);
    k = 0;
    while ((fcnt % 8) != 4 && k < 16) begin @(posedge clk); #1; k++; end
    i2c_busy = 0;
    repeat (20) @(posedge clk);
    #1;
    check("one_wr_after_release", wr_count, c0 + 1);
    wait_done();
    check("peak_320", peak_pos, 320);
    check("park_pos_320", vcm_pos, 320);
    check("end_320", vcm_end, 1);

    // Peak at 0 with all-ones sharpness, new sweep from VCM_END=1
    start_sweep(1);
    check("model_fine_lo_0", first_fine, 0);
    check("model_fine_hi_0", last_fine, 32);
    wait_done();
    check("peak_0", peak_pos, 0);

    // Peak at 1023: last coarse 992, fine clamped at 1023
    start_sweep(2);
    check("model_last_coarse", last_coarse, 992);
    check("model_fine_hi_1023", last_fine, 1020);
    wait_done();
    check("peak_1023", peak_pos, 1020);

    // Tie at 96 and 128 keeps the earlier position
    start_sweep(3);
    wait_done();
    check("peak_tie", peak_pos, 96);

    // Reset during the fine phase, then restart from 0
    start_sweep(0);
    wait_wr(36);
    do_reset();
    start_sweep(0);
    wait_wr(1);
    check("restart_pos0", vcm_pos, 0);
    wait_done();
    check("peak_restart", peak_pos, 320);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
